// File: rtl/program_loader_if.sv
// Loader-side signal bundle: start/status, byte stream in, RAM program port out.
// master = loader, slave = host/bench driving bytes and observing the RAM port.
interface program_loader_if;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_program_mode;
  logic [7:0]  o_program_address;
  logic [15:0] o_program_data;
  logic        o_write_enable;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;

  modport master (
    input  i_start, i_byte, i_byte_valid,
    output o_byte_ready, o_program_mode, o_program_address, o_program_data,
           o_write_enable, o_cpu_reset, o_done, o_error
  );

  modport slave (
    output i_start, i_byte, i_byte_valid,
    input  o_byte_ready, o_program_mode, o_program_address, o_program_data,
           o_write_enable, o_cpu_reset, o_done, o_error
  );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: count byte, then {hi,lo} word pairs written to RAM, 1 word / 3 cycles; stalls on !i_byte_valid.
// Optional trailing mod-256 checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  program_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, COUNT, HIGH, LOW, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr;
  logic [7:0]  data_hi, data_lo;
  logic [8:0]  remaining;
  logic        first_word;
  logic        byte_ready, program_mode, write_enable, cpu_reset, done, error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  always_comb begin
    state_nxt    = state;
    byte_ready   = 1'b0;
    program_mode = 1'b0;
    write_enable = 1'b0;
    cpu_reset    = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) state_nxt = COUNT;
      end
      COUNT: begin
        program_mode = 1'b1;
        byte_ready   = 1'b1;
        if (bus.i_byte_valid) state_nxt = HIGH;
      end
      HIGH: begin
        program_mode = 1'b1;
        byte_ready   = 1'b1;
        if (bus.i_byte_valid) state_nxt = LOW;
      end
      LOW: begin
        program_mode = 1'b1;
        byte_ready   = 1'b1;
        if (bus.i_byte_valid) state_nxt = WRITE;
      end
      WRITE: begin
        program_mode = 1'b1;
        write_enable = 1'b1;
        if (remaining != 9'd1) begin
          state_nxt = HIGH;
        end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
      CHECK: begin
        program_mode = 1'b1;
        byte_ready   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (bus.i_byte_valid) state_nxt = (bus.i_byte == sum) ? DONE : ERROR;
`else
        state_nxt = DONE;
`endif
      end
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (bus.i_start) state_nxt = COUNT;
      end
      ERROR: begin
        error = 1'b1;
        if (bus.i_start) state_nxt = COUNT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address advances when the next word's high byte arrives, so it holds through the stall after WRITE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      addr       <= BASE_ADDR;
      data_hi    <= 8'd0;
      data_lo    <= 8'd0;
      remaining  <= 9'd0;
      first_word <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        COUNT: if (bus.i_byte_valid) begin
          remaining  <= (bus.i_byte == 8'd0) ? 9'd256 : {1'b0, bus.i_byte};
          addr       <= BASE_ADDR;
          first_word <= 1'b1;
        end
        HIGH: if (bus.i_byte_valid) begin
          data_hi    <= bus.i_byte;
          first_word <= 1'b0;
          if (!first_word) addr <= addr + 8'd1;
        end
        LOW: if (bus.i_byte_valid) data_lo <= bus.i_byte;
        WRITE: remaining <= remaining - 9'd1;
        default: ;
      endcase
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sum <= 8'd0;
    end else if (bus.i_byte_valid) begin
      if (state == COUNT) sum <= bus.i_byte;
      else if (state == HIGH || state == LOW) sum <= sum + bus.i_byte;
    end
  end
  assign bus.o_error = error;
`else
  assign bus.o_error = 1'b0;
`endif

  assign bus.o_byte_ready      = byte_ready;
  assign bus.o_program_mode    = program_mode;
  assign bus.o_program_address = addr;
  assign bus.o_program_data    = {data_hi, data_lo};
  assign bus.o_write_enable    = write_enable;
  assign bus.o_cpu_reset       = cpu_reset;
  assign bus.o_done            = done;

  logic unused_error;
  assign unused_error = error;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'd0: RAM address of the first loaded word.
REQ-002 i_clock  input  1  system clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset; synchronous, active-high.
REQ-004 i_start  input  1  one-cycle pulse to begin a load.
REQ-005 i_byte  input  8  incoming program byte from the serial receiver.
REQ-006 i_byte_valid  input  1  i_byte is valid this cycle.
REQ-007 o_byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs only when i_byte_valid and o_byte_ready are both high.
REQ-008 o_program_mode  output  1  drives the RAM program-mode select.
REQ-009 o_program_address  output  8  RAM program-port address.
REQ-010 o_program_data  output  16  RAM program-port word, {opcode, operand}.
REQ-011 o_write_enable  output  1  one-cycle RAM write strobe.
REQ-012 o_cpu_reset  output  1  holds the CPU (program counter, registers, controller) in reset.
REQ-013 o_done  output  1  load completed successfully; level.
REQ-014 o_error  output  1  load failed; level.

Function
REQ-015 The loader SHALL use states IDLE, COUNT, HIGH, LOW, WRITE, CHECK, DONE, ERROR.
REQ-016 IDLE: o_byte_ready=0, o_cpu_reset=1; i_start moves to COUNT; bytes are ignored.
REQ-017 COUNT: o_program_mode=1, o_byte_ready=1; accepted byte is the word count N; N=0 means 256 words; address is set to BASE_ADDR; moves to HIGH.
REQ-018 HIGH: accepted byte is stored as o_program_data[15:8]; moves to LOW.
REQ-019 LOW: accepted byte is stored as o_program_data[7:0]; moves to WRITE.
REQ-020 WRITE: lasts exactly one cycle with o_write_enable=1 and o_byte_ready=0; address and data are stable from this cycle until the next accepted byte.
REQ-021 After WRITE, the address increments modulo 256 (0xFF wraps to 0x00) and the remaining count decrements; the next state is HIGH if words remain, otherwise CHECK (or DONE when the checksum is compiled out).
REQ-022 Minimum latency: one word per 3 cycles (HIGH, LOW, WRITE) with i_byte_valid held high.
REQ-023 While i_byte_valid=0, the loader SHALL stall in its current state with no output change.
REQ-024 DONE: o_done=1, o_cpu_reset=0, o_program_mode=0, o_byte_ready=0.
REQ-025 ERROR: o_error=1, o_cpu_reset=1, o_program_mode=0, o_byte_ready=0.
REQ-026 i_start SHALL be ignored in COUNT, HIGH, LOW, WRITE and CHECK.
REQ-027 i_start in DONE or ERROR SHALL clear o_done/o_error, set o_cpu_reset=1, and enter COUNT on the next cycle.
REQ-028 o_write_enable SHALL never be high for more than one consecutive cycle, and only in WRITE.

Reset
REQ-029 When i_reset=1 at a rising edge, the loader SHALL enter IDLE with: o_cpu_reset=1, o_program_mode=0, o_byte_ready=0, o_write_enable=0, o_program_address=BASE_ADDR, o_program_data=0, o_done=0, o_error=0.
REQ-030 Reset takes priority over i_start and byte transfers.
REQ-031 Reset mid-load SHALL abort the load with no write strobe in the cycle following reset.

Configuration
REQ-032 Macro PROGRAM_LOADER_CHECKSUM_EN defined: after the last WRITE, CHECK accepts one byte; the load goes to DONE if that byte equals the mod-256 sum of the count byte and all data bytes, else to ERROR.
REQ-033 Macro undefined: CHECK is never entered, the last WRITE goes directly to DONE, and o_error is tied to 0.

Verification
REQ-034 i_start; bytes 04,00,FF,01,7F,02,01,07,02 (+ checksum 8F when enabled) -> writes addr0=00FF, addr1=017F, addr2=0201, addr3=0702, then o_done=1 and o_cpu_reset=0.
REQ-035 Same stream with i_byte_valid toggled every other cycle -> identical writes and order; o_write_enable pulses exactly 4 times.
REQ-036 Checksum enabled, count 01, bytes 05,0A, checksum 00 -> one write, then o_error=1 and o_cpu_reset=1; a following i_start with correct checksum 10 -> o_done=1.
REQ-037 BASE_ADDR=8'hFE, count 03 -> writes at addresses FE, FF, 00.
REQ-038 i_reset asserted after 3 accepted data bytes -> IDLE, no further write strobe, all outputs at reset values.
REQ-039 Bytes presented with valid high while in IDLE, then i_start pulsed during HIGH -> no bytes accepted in IDLE; the i_start pulse has no effect.
